byte_packer: RTL

Byte-to-word packer: accepts a stream of 8-bit bytes over a valid/ready handshake and emits each group of four as one 32-bit word over a second valid/ready handshake. It is the inverse of the team's combinational word-to-byte splitter. The first byte received lands in bits [31:24] and the fourth in bits [7:0], so packing a word and then splitting it returns the original bytes in order. It sits between a byte-serial source (UART/bus adapter) and word-wide datapath logic.

---
 rtl/byte_packer.sv | 75 +++++++
 1 files changed

// File: rtl/byte_packer.sv
// Byte-to-word packer: four bytes in over valid/ready, one 32-bit word out.
// First byte lands in [31:24]; the fourth byte completes the word.
module byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  count
);

   typedef enum logic [1:0] {
      FILL0 = 2'd0,
      FILL1 = 2'd1,
      FILL2 = 2'd2,
      FILL3 = 2'd3
   } state_e;

   state_e      state_q;
   logic [23:0] asm_q;
   logic [31:0] data_q;
   logic        valid_q;

   logic        in_fire;
   logic        out_fire;

   // Only the completing byte can be blocked by a pending word.
   assign in_ready = (state_q != FILL3) || !valid_q || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = valid_q && out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FILL0;
         asm_q   <= 24'h00_0000;
         data_q  <= 32'h0000_0000;
         valid_q <= 1'b0;
      end else begin
         if (out_fire) begin
            valid_q <= 1'b0;
         end
         if (in_fire) begin
            unique case (state_q)
               FILL0: begin
                  asm_q[23:16] <= in_data;
                  state_q      <= FILL1;
               end
               FILL1: begin
                  asm_q[15:8] <= in_data;
                  state_q     <= FILL2;
               end
               FILL2: begin
                  asm_q[7:0] <= in_data;
                  state_q    <= FILL3;
               end
               FILL3: begin
                  // Overrides the drain above when both happen together.
                  data_q  <= {asm_q, in_data};
                  valid_q <= 1'b1;
                  state_q <= FILL0;
               end
               default: state_q <= FILL0;
            endcase
         end
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign count     = state_q;

endmodule
